bram_out_8192: RTL and testbench
================================

BRAM_OUT_8192 -- requirements
Module: bram_out_8192

Interface
REQ-001 Parameter FLOAT_LEN, default 32, width of one float; each complex sample is 2*FLOAT_LEN bits, {re, im}.
REQ-002 Parameter ADDR_W, default 13; frame length is 2^ADDR_W = 8192 samples.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 arm  input  1  1-cycle pulse; starts a capture from IDLE.
REQ-006 data_in  input  2*FLOAT_LEN  FFT result sample to store.
REQ-007 data_in_valid  input  1  data_in is valid this cycle.
REQ-008 rd_en  input  1  request next stored sample during readout.
REQ-009 data_out  output  2*FLOAT_LEN  readback sample.
REQ-010 data_out_valid  output  1  data_out is valid; rd_en delayed one cycle.
REQ-011 full  output  1  frame captured and awaiting readout; high in state FULL.
REQ-012 done  output  1  1-cycle pulse after the last sample is read.
REQ-013 overflow  output  1  sticky; a sample arrived while in FULL.

Function
REQ-014 The FSM SHALL have four states: IDLE, CAPTURE, FULL, DRAIN.
REQ-015 IDLE->CAPTURE on arm; wr_addr SHALL clear to 0 on that edge.
REQ-016 In CAPTURE, each data_in_valid cycle SHALL write data_in at wr_addr, then wr_addr+1.
REQ-017 A write at wr_addr = 2^ADDR_W-1 SHALL move to FULL on the same edge; wr_addr wraps to 0.
REQ-018 In FULL, the first rd_en SHALL enter DRAIN; in FULL and DRAIN each rd_en reads rd_addr, then rd_addr+1.
REQ-019 A read at rd_addr = 2^ADDR_W-1 SHALL return to IDLE, wrap rd_addr to 0, and pulse done on the next cycle, coincident with the last data_out_valid.
REQ-020 Read latency SHALL be exactly 1 cycle: data_out_valid(t+1) = rd_en(t) accepted at t; data_out holds RAM[rd_addr(t)].
REQ-021 rd_en outside FULL/DRAIN SHALL be ignored: no address change, data_out_valid stays 0.
REQ-022 arm outside IDLE SHALL be ignored.
REQ-023 data_in_valid in IDLE SHALL be dropped silently; in FULL or DRAIN it SHALL be dropped and SHALL set overflow.
REQ-024 overflow SHALL clear only on rst or on the next arm accepted in IDLE.
REQ-025 arm and data_in_valid in the same IDLE cycle: the sample SHALL be dropped; capture starts with the next valid.
REQ-026 full SHALL be 1 in FULL and DRAIN, and 0 otherwise.
REQ-027 Gaps in data_in_valid or rd_en SHALL be tolerated with no sample lost or duplicated.

Reset
REQ-028 On rst: state IDLE; wr_addr and rd_addr 0; data_out_valid, full, done and overflow 0; data_out 0.
REQ-029 rst mid-capture or mid-drain SHALL abort the operation on that edge; RAM contents are not cleared.

Structure
REQ-030 FLOAT_LEN, ADDR_W and the state encoding SHALL live in the shared package fft_pkg.
REQ-031 Storage SHALL be one sub-module, bram_sdp_8192: simple dual-port, write port A, registered read port B, 1-cycle latency, inferred.
REQ-032 All addressing and FSM logic SHALL be in bram_out_8192; the RAM holds no control logic.

Verification
REQ-033 Full frame: arm, then 8192 contiguous valids with data_in = {index, ~index} -> full rises the cycle after the 8192nd write; 8192 rd_en give matching data in order, 1-cycle latency, and done with the last valid.
REQ-034 Gapped traffic: valids every 3rd cycle and random rd_en gaps -> identical data, no drop or duplicate.
REQ-035 Overflow: 5 extra valids in FULL -> overflow=1 and stored data unchanged; next arm clears overflow.
REQ-036 Ignored inputs: rd_en in IDLE and CAPTURE gives no data_out_valid; arm in CAPTURE does not reset wr_addr.
REQ-037 Reset abort: rst after 100 captured samples -> all outputs 0, state IDLE; a new arm captures from address 0.
REQ-038 Same-cycle arm and data_in_valid in IDLE -> that sample is not stored; the first stored word is the next valid.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT output-buffer parameters and the capture FSM state encoding.
package fft_pkg;

    localparam int unsigned FLOAT_LEN = 32;  // width of one float; a sample is {re, im}
    localparam int unsigned ADDR_W    = 13;  // frame length is 2**ADDR_W samples

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StFull,
        StDrain
    } bram_state_e;

endpackage

// File: rtl/bram_sdp_8192.sv
// Simple dual-port RAM: write port A, registered read port B (1-cycle latency).
// Pure storage; all sequencing lives in the parent.
module bram_sdp_8192 #(
    parameter int unsigned DATA_W = 2 * fft_pkg::FLOAT_LEN,
    parameter int unsigned ADDR_W = fft_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Port A: synchronous write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Port B: registered read, output held between reads.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/bram_out_8192.sv
// FFT result buffer: captures one frame of complex samples, then plays it back
// on demand. Samples arriving while a frame is waiting to be read are dropped
// and flagged through a sticky overflow bit.
module bram_out_8192
    import fft_pkg::*;
#(
    parameter int unsigned FLOAT_LEN = fft_pkg::FLOAT_LEN,
    parameter int unsigned ADDR_W    = fft_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic [2*FLOAT_LEN-1:0] data_in,
    input  logic                   data_in_valid,
    input  logic                   rd_en,
    output logic [2*FLOAT_LEN-1:0] data_out,
    output logic                   data_out_valid,
    output logic                   full,
    output logic                   done,
    output logic                   overflow
);

    localparam logic [ADDR_W-1:0] LastAddr = '1;

    bram_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              overflow_q, overflow_d;
    logic              dout_valid_q, done_q, done_d;
    logic              ram_we, rd_accept;
    logic [2*FLOAT_LEN-1:0] ram_rdata;

    // Next-state, address and flag logic.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        overflow_d = overflow_q;
        ram_we     = 1'b0;
        rd_accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A valid in the same cycle as arm is dropped; capture starts next valid.
                if (arm) begin
                    state_d    = StCapture;
                    wr_addr_d  = '0;
                    overflow_d = 1'b0;
                end
            end
            StCapture: begin
                if (data_in_valid) begin
                    ram_we    = 1'b1;
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    if (wr_addr_q == LastAddr) begin
                        state_d = StFull;
                    end
                end
            end
            StFull, StDrain: begin
                if (data_in_valid) begin
                    overflow_d = 1'b1;
                end
                if (rd_en) begin
                    rd_accept = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    state_d   = (rd_addr_q == LastAddr) ? StIdle : StDrain;
                end
            end
        endcase
        done_d = rd_accept && (rd_addr_q == LastAddr);
    end

    // State and control registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            overflow_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            overflow_q   <= overflow_d;
            dout_valid_q <= rd_accept;
            done_q       <= done_d;
        end
    end

    bram_sdp_8192 #(
        .DATA_W (2 * FLOAT_LEN),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_addr_q),
        .wr_data (data_in),
        .rd_en   (rd_accept),
        .rd_addr (rd_addr_q),
        .rd_data (ram_rdata)
    );

    // The RAM output register has no reset, so present zero whenever no read is due.
    assign data_out       = dout_valid_q ? ram_rdata : '0;
    assign data_out_valid = dout_valid_q;
    assign full           = (state_q == StFull) || (state_q == StDrain);
    assign done           = done_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_bram_out_8192.sv
// Randomized self-checking bench for bram_out_8192. The reference is a queue
// of the words the bench has actually handed to the buffer in the current
// frame; readback must reproduce that queue exactly, in order.
module tb_bram_out_8192;

    localparam int FL = 32;
    localparam int AW = 13;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, arm, data_in_valid, rd_en;
    logic [2*FL-1:0] data_in, data_out;
    logic          data_out_valid, full, done, overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*FL-1:0] frame [$];

    always #5 clk = ~clk;

    bram_out_8192 #(
        .FLOAT_LEN (FL),
        .ADDR_W    (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .rd_en          (rd_en),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .full           (full),
        .done           (done),
        .overflow       (overflow)
    );

    task automatic check(input string tag, input logic [2*FL-1:0] got,
                         input logic [2*FL-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs are sampled at the edge; outputs are inspected 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*FL-1:0] mk_word(input int idx, input int salt);
        logic [FL-1:0] v;
        v = FL'(idx) ^ FL'(salt);
        return {v, ~v};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, data_out_valid, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_data"}, data_out, 0);
    endtask

    // Feed one whole frame; one valid every `gap` cycles. Random rd_en is
    // thrown in throughout and must never produce readout during capture.
    task automatic capture(input int gap, input int arm_at, input int salt);
        frame.delete();
        for (int i = 0; i < N; i++) begin
            for (int g = 1; g < gap; g++) begin
                data_in_valid = 1'b0;
                data_in       = 64'($urandom);
                rd_en         = 1'($urandom);
                tick();
                check("cap_gap_valid", data_out_valid, 0);
            end
            data_in_valid = 1'b1;
            data_in       = mk_word(i, salt);
            rd_en         = 1'($urandom);
            arm           = (i == arm_at);
            frame.push_back(data_in);
            tick();
            arm = 1'b0;
            check("cap_full", full, (i == N - 1));
            check("cap_valid", data_out_valid, 0);
        end
        data_in_valid = 1'b0;
        rd_en         = 1'b0;
    endtask

    // Read the frame back; gap_pct is the chance of idling rd_en in a cycle.
    task automatic drain(input int gap_pct);
        int  issued = 0;
        int  cyc    = 0;
        logic rd;
        while (issued < N && cyc < 4 * N) begin
            rd    = ($urandom_range(0, 99) >= gap_pct);
            rd_en = rd;
            tick();
            check("rd_valid", data_out_valid, rd);
            if (rd) check("rd_data", data_out, frame[issued]);
            check("rd_done", done, rd && (issued == N - 1));
            check("rd_full", full, (issued + int'(rd)) < N);
            if (rd) issued++;
            cyc++;
        end
        rd_en = 1'b0;
        check("drain_count", issued, N);
        tick();
        check("post_drain_valid", data_out_valid, 0);
        check("post_drain_done", done, 0);
        check("post_drain_full", full, 0);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; data_in_valid = 1'b0; rd_en = 1'b0; data_in = '0;
        tick();
        tick();
        rst = 1'b0;
        check_idle_outputs("reset");

        // rd_en in IDLE is ignored.
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            tick();
            check("idle_rd_valid", data_out_valid, 0);
            check("idle_rd_full", full, 0);
        end
        rd_en = 1'b0;

        // Frame 1: contiguous capture of {index, ~index}, contiguous readout.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("armed_full", full, 0);
        capture(1, -1, 0);
        drain(0);

        // Frame 2: valid every 3rd cycle, randomly gapped reads.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        capture(3, -1, 32'h5a5a_1234);
        drain(30);

        // Reset abort after 100 captured samples.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 100; i++) begin
            data_in_valid = 1'b1;
            data_in       = 64'($urandom);
            tick();
        end
        data_in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("abort");

        // Arm with a same-cycle valid: that word must not be stored. A second
        // arm mid-capture must not restart addressing.
        arm           = 1'b1;
        data_in_valid = 1'b1;
        data_in       = 64'hdead_beef_dead_beef;
        tick();
        arm           = 1'b0;
        data_in_valid = 1'b0;
        capture(1, 50, 32'h0f0f_a5a5);

        // Overflow: extra valids while FULL are dropped and flagged.
        check("ovf_before", overflow, 0);
        for (int i = 0; i < 5; i++) begin
            data_in_valid = 1'b1;
            data_in       = 64'($urandom);
            tick();
            check("ovf_set", overflow, 1);
            check("ovf_full", full, 1);
        end
        data_in_valid = 1'b0;
        drain(0);
        check("ovf_sticky", overflow, 1);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("ovf_cleared", overflow, 0);
        check("rearm_full", full, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
